// File: rtl/bus_gate_arbiter.sv
// bus_gate_arbiter
//   Hands the shared 16-bit processor bus to one tri-state gate driver at a
//   time (0=ALU, 1=MARMUX, 2=PC, 3=MDR, 4=SHF). Arbitration is round-robin,
//   turnaround idle cycles separate owners, and an owner that has held the
//   bus for MAX_HOLD cycles is forced off when anyone else is waiting.
//
//   Optional feature macro: BUS_ARB_FIXED_PRIO_EN
//     defined   -> fixed priority (lowest index wins); a forced-off owner is
//                  excluded from the one arbitration that follows its release.
//     undefined -> round-robin starting after the last winner.
//
// Ports
//   clock          in   system clock, rising edge
//   reset_n        in   asynchronous active-low reset
//   req            in   [NUM_REQ]  level-sensitive bus requests
//   gate           out  [NUM_REQ]  registered one-hot (or zero) gate enables
//   owner_id       out  [ID_W]     current owner, meaningful while bus_busy=1
//   bus_busy       out             1 while a gate is enabled
//   forced_release out             1-cycle pulse after a forced release
module bus_gate_arbiter #(
  parameter int NUM_REQ    = 5,
  parameter int ID_W       = 3,
  parameter int MAX_HOLD   = 4,
  parameter int TURNAROUND = 1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gate,
  output logic [ID_W-1:0]    owner_id,
  output logic               bus_busy,
  output logic               forced_release
);

  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_e;

  localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);
  localparam logic [1:0] TURN_LEN = 2'(TURNAROUND);

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] gate_q, gate_d;
  logic [ID_W-1:0]    owner_q, owner_d;
  logic               forced_q, forced_d;
  logic [3:0]         hold_q, hold_d;
  logic [1:0]         turn_q, turn_d;
`ifdef BUS_ARB_FIXED_PRIO_EN
  logic [NUM_REQ-1:0] excl_q, excl_d;   // owner barred from the next arbitration
`else
  logic [ID_W-1:0]    rr_q, rr_d;       // last winner; search starts after it
`endif

  logic [NUM_REQ-1:0] owner_oh;
  logic               forced_now;
  logic [NUM_REQ-1:0] arb_req;
  logic               win_vld;
  logic [ID_W-1:0]    win_id;

  assign owner_oh = NUM_REQ'(1) << owner_q;

  // Owner still wants the bus but has used its quota and someone else waits.
  assign forced_now = (state_q == GRANT) && req[owner_q] &&
                      (hold_q == HOLD_MAX) && ((req & ~owner_oh) != '0);

  // Arbitration over the (possibly masked) request vector.
`ifdef BUS_ARB_FIXED_PRIO_EN
  always_comb begin
    arb_req = req;
    if (state_q == GRANT && forced_now) arb_req = req & ~owner_oh;
    else if (state_q == TURN)           arb_req = req & ~excl_q;
    win_vld = 1'b0;
    win_id  = '0;
    // Descending scan: the last hit, i.e. the lowest index, wins.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (arb_req[i]) begin
        win_vld = 1'b1;
        win_id  = ID_W'(i);
      end
    end
  end
`else
  int              idx;
  logic [ID_W-1:0] sel;
  always_comb begin
    arb_req = req;
    win_vld = 1'b0;
    win_id  = '0;
    idx     = 0;
    sel     = '0;
    // Scan offsets far-to-near so the nearest requester after rr_q wins.
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = int'(rr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      sel = ID_W'(idx);
      if (arb_req[sel]) begin
        win_vld = 1'b1;
        win_id  = sel;
      end
    end
  end
`endif

  // Next-state / output logic
  always_comb begin
    state_d  = state_q;
    gate_d   = gate_q;
    owner_d  = owner_q;
    forced_d = 1'b0;
    hold_d   = hold_q;
    turn_d   = turn_q;
`ifdef BUS_ARB_FIXED_PRIO_EN
    excl_d   = excl_q;
`else
    rr_d     = rr_q;
`endif
    case (state_q)
      IDLE: begin
        gate_d = '0;
        if (win_vld) begin
          state_d = GRANT;
          gate_d  = NUM_REQ'(1) << win_id;
          owner_d = win_id;
          hold_d  = 4'd1;
`ifndef BUS_ARB_FIXED_PRIO_EN
          rr_d    = win_id;
`endif
        end
      end
      GRANT: begin
        if (req[owner_q] && !forced_now) begin
          if (hold_q != HOLD_MAX) hold_d = 4'(hold_q + 4'd1);
        end else begin
          forced_d = forced_now;
`ifdef BUS_ARB_FIXED_PRIO_EN
          excl_d   = forced_now ? owner_oh : '0;
`endif
          if (TURNAROUND > 0) begin
            state_d = TURN;
            gate_d  = '0;
            turn_d  = 2'd1;
          end else if (win_vld) begin
            // Zero turnaround: hand over on the same edge.
            state_d = GRANT;
            gate_d  = NUM_REQ'(1) << win_id;
            owner_d = win_id;
            hold_d  = 4'd1;
`ifndef BUS_ARB_FIXED_PRIO_EN
            rr_d    = win_id;
`endif
          end else begin
            state_d = IDLE;
            gate_d  = '0;
          end
        end
      end
      TURN: begin
        gate_d = '0;
        if (turn_q == TURN_LEN) begin
          if (win_vld) begin
            state_d = GRANT;
            gate_d  = NUM_REQ'(1) << win_id;
            owner_d = win_id;
            hold_d  = 4'd1;
`ifndef BUS_ARB_FIXED_PRIO_EN
            rr_d    = win_id;
`endif
          end else begin
            state_d = IDLE;
          end
        end else begin
          turn_d = 2'(turn_q + 2'd1);
        end
      end
      default: begin
        state_d = IDLE;
        gate_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      gate_q   <= '0;
      owner_q  <= '0;
      forced_q <= 1'b0;
      hold_q   <= '0;
      turn_q   <= '0;
`ifdef BUS_ARB_FIXED_PRIO_EN
      excl_q   <= '0;
`else
      rr_q     <= ID_W'(NUM_REQ - 1);
`endif
    end else begin
      state_q  <= state_d;
      gate_q   <= gate_d;
      owner_q  <= owner_d;
      forced_q <= forced_d;
      hold_q   <= hold_d;
      turn_q   <= turn_d;
`ifdef BUS_ARB_FIXED_PRIO_EN
      excl_q   <= excl_d;
`else
      rr_q     <= rr_d;
`endif
    end
  end

  assign gate           = gate_q;
  assign owner_id       = owner_q;
  assign bus_busy       = |gate_q;
  assign forced_release = forced_q;

endmodule
